// File: rtl/ctrl_seq_unit_if.sv
// rtl/ctrl_seq_unit_if.sv - ID-stage decode/sequencer interface
// master: fetch/ID side driving instruction fields; slave: ctrl_seq_unit.
interface ctrl_seq_unit_if #(
  parameter int NUM_REGS  = 16,
  parameter int REG_IDX_W = 4,
  parameter int OFFSET_W  = 8
) ();
  logic                 flush;
  logic                 freeze;
  logic                 valid_in;
  logic [1:0]           mode;
  logic [3:0]           op_code;
  logic                 s_in;
  logic                 i_bit;
  logic [NUM_REGS-1:0]  reg_list;
  logic [3:0]           exe_cmd;
  logic                 mem_r_en;
  logic                 mem_w_en;
  logic                 wb_en;
  logic                 b_out;
  logic                 s_out;
  logic [REG_IDX_W-1:0] dest_reg;
  logic [OFFSET_W-1:0]  offset;
  logic                 valid_out;
  logic                 undef;
  logic                 busy;

  modport master (
    output flush, freeze, valid_in, mode, op_code, s_in, i_bit, reg_list,
    input  exe_cmd, mem_r_en, mem_w_en, wb_en, b_out, s_out, dest_reg, offset,
           valid_out, undef, busy
  );

  modport slave (
    input  flush, freeze, valid_in, mode, op_code, s_in, i_bit, reg_list,
    output exe_cmd, mem_r_en, mem_w_en, wb_en, b_out, s_out, dest_reg, offset,
           valid_out, undef, busy
  );
endinterface

// File: rtl/ctrl_seq_unit.sv
// rtl/ctrl_seq_unit.sv - registered control decoder with LDM/STM micro-op sequencer
// Outputs are registered at the ID/EX boundary; block transfers emit one micro-op per list bit.
module ctrl_seq_unit #(
  parameter int NUM_REGS  = 16,
  parameter int REG_IDX_W = 4,
  parameter int OFFSET_W  = 8,
  parameter int ADDR_STEP = 4
) (
  input  logic           clk,
  input  logic           rst,
  ctrl_seq_unit_if.slave bus
);

  typedef enum logic {S_DECODE, S_BLOCK} state_t;

  state_t               r_state;
  logic [NUM_REGS-1:0]  r_list;
  logic                 r_l;
  logic [3:0]           r_exe_cmd;
  logic                 r_mem_r_en;
  logic                 r_mem_w_en;
  logic                 r_wb_en;
  logic                 r_b_out;
  logic                 r_s_out;
  logic [REG_IDX_W-1:0] r_dest_reg;
  logic [OFFSET_W-1:0]  r_offset;
  logic                 r_valid_out;
  logic                 r_undef;

  logic [NUM_REGS-1:0]  w_blk_list;
  logic [NUM_REGS-1:0]  w_rest;
  logic [REG_IDX_W-1:0] w_idx;
  logic                 w_blk_l;
  logic [3:0]           w_dp_exe;
  logic                 w_dp_cmp;

  function automatic logic [3:0] f_exe(input logic [3:0] op);
    case (op)
      4'b1101: f_exe = 4'b0001;
      4'b1111: f_exe = 4'b1001;
      4'b0100: f_exe = 4'b0010;
      4'b0101: f_exe = 4'b0011;
      4'b0010: f_exe = 4'b0100;
      4'b0110: f_exe = 4'b0101;
      4'b0000: f_exe = 4'b0110;
      4'b1100: f_exe = 4'b0111;
      4'b0001: f_exe = 4'b1000;
      4'b1010: f_exe = 4'b0100;
      4'b1000: f_exe = 4'b0110;
      default: f_exe = 4'b0001;
    endcase
  endfunction

  // Downward scan so the last hit is the lowest set bit.
  function automatic logic [REG_IDX_W-1:0] f_low_idx(input logic [NUM_REGS-1:0] v);
    f_low_idx = '0;
    for (int k = NUM_REGS - 1; k >= 0; k--) begin
      if (v[k]) f_low_idx = REG_IDX_W'(k);
    end
  endfunction

  // In BLOCK the latched remainder drives selection; in DECODE the live inputs do.
  assign w_blk_list = (r_state == S_BLOCK) ? r_list : bus.reg_list;
  assign w_blk_l    = (r_state == S_BLOCK) ? r_l : bus.s_in;
  assign w_idx      = f_low_idx(w_blk_list);
  assign w_rest     = w_blk_list & ~({{(NUM_REGS-1){1'b0}}, 1'b1} << w_idx);
  assign w_dp_exe   = f_exe(bus.op_code);
  assign w_dp_cmp   = (bus.op_code == 4'b1010) || (bus.op_code == 4'b1000);

  always_ff @(posedge clk) begin
    if (!rst || bus.flush) begin
      r_state     <= S_DECODE;
      r_list      <= '0;
      r_l         <= 1'b0;
      r_exe_cmd   <= 4'b0000;
      r_mem_r_en  <= 1'b0;
      r_mem_w_en  <= 1'b0;
      r_wb_en     <= 1'b0;
      r_b_out     <= 1'b0;
      r_s_out     <= 1'b0;
      r_dest_reg  <= '0;
      r_offset    <= '0;
      r_valid_out <= 1'b0;
      r_undef     <= 1'b0;
    end else if (!bus.freeze) begin
      r_exe_cmd   <= 4'b0000;
      r_mem_r_en  <= 1'b0;
      r_mem_w_en  <= 1'b0;
      r_wb_en     <= 1'b0;
      r_b_out     <= 1'b0;
      r_s_out     <= 1'b0;
      r_dest_reg  <= '0;
      r_offset    <= '0;
      r_valid_out <= 1'b0;
      r_undef     <= 1'b0;
      case (r_state)
        S_DECODE: begin
          if (bus.valid_in) begin
            r_valid_out <= 1'b1;
            case (bus.mode)
              2'b00: begin
                r_exe_cmd <= w_dp_exe;
                r_s_out   <= bus.s_in;
                r_wb_en   <= !w_dp_cmp;
              end
              2'b01: begin
                r_exe_cmd  <= 4'b0010;
                r_mem_r_en <= bus.s_in;
                r_wb_en    <= bus.s_in;
                r_mem_w_en <= !bus.s_in;
              end
              2'b10: begin
                if (bus.i_bit) begin
                  r_b_out <= 1'b1;
                end else begin
                  r_exe_cmd <= 4'b0010;
                  if (|bus.reg_list) begin
                    r_mem_r_en <= w_blk_l;
                    r_wb_en    <= w_blk_l;
                    r_mem_w_en <= !w_blk_l;
                    r_dest_reg <= w_idx;
                    r_list     <= w_rest;
                    r_l        <= w_blk_l;
                    r_state    <= (|w_rest) ? S_BLOCK : S_DECODE;
                  end
                end
              end
              default: begin
                r_undef <= 1'b1;
              end
            endcase
          end
        end
        S_BLOCK: begin
          r_valid_out <= 1'b1;
          r_exe_cmd   <= 4'b0010;
          r_mem_r_en  <= w_blk_l;
          r_wb_en     <= w_blk_l;
          r_mem_w_en  <= !w_blk_l;
          r_dest_reg  <= w_idx;
          r_offset    <= r_offset + OFFSET_W'(ADDR_STEP);
          r_list      <= w_rest;
          r_state     <= (|w_rest) ? S_BLOCK : S_DECODE;
        end
        default: r_state <= S_DECODE;
      endcase
    end
  end

  assign bus.exe_cmd   = r_exe_cmd;
  assign bus.mem_r_en  = r_mem_r_en;
  assign bus.mem_w_en  = r_mem_w_en;
  assign bus.wb_en     = r_wb_en;
  assign bus.b_out     = r_b_out;
  assign bus.s_out     = r_s_out;
  assign bus.dest_reg  = r_dest_reg;
  assign bus.offset    = r_offset;
  assign bus.valid_out = r_valid_out;
  assign bus.undef     = r_undef;
  assign bus.busy      = (r_state == S_BLOCK);

endmodule

// File: tb/tb_ctrl_seq_unit.sv
// tb/tb_ctrl_seq_unit.sv - scoreboard bench for ctrl_seq_unit
// Driver queues one expected output word per clock edge; a negedge monitor pops and compares.
module tb_ctrl_seq_unit;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ctrl_seq_unit_if #(.NUM_REGS(16), .REG_IDX_W(4), .OFFSET_W(8)) bus ();

  ctrl_seq_unit #(.NUM_REGS(16), .REG_IDX_W(4), .OFFSET_W(8), .ADDR_STEP(4)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  typedef struct {
    logic [23:0] exp;
    string       name;
  } exp_t;

  exp_t        q[$];
  int          n_pass = 0;
  int          n_chk  = 0;
  logic [23:0] act;

  assign act = {bus.valid_out, bus.undef, bus.busy, bus.exe_cmd, bus.mem_r_en, bus.mem_w_en,
                bus.wb_en, bus.b_out, bus.s_out, bus.dest_reg, bus.offset};

  // valid, undef, busy, exe_cmd, mem_r, mem_w, wb, b, s, dest, offset
  function automatic logic [23:0] mk(input logic v, input logic u, input logic bz,
                                     input logic [3:0] exe, input logic r, input logic w,
                                     input logic wb, input logic b, input logic s,
                                     input logic [3:0] dest, input logic [7:0] off);
    mk = {v, u, bz, exe, r, w, wb, b, s, dest, off};
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      n_chk++;
      if (act === e.exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", e.name, act, e.exp);
    end
  end

  task automatic set_in(input logic v, input logic [1:0] m, input logic [3:0] op,
                        input logic s, input logic ib, input logic [15:0] lst);
    bus.valid_in = v;
    bus.mode     = m;
    bus.op_code  = op;
    bus.s_in     = s;
    bus.i_bit    = ib;
    bus.reg_list = lst;
  endtask

  task automatic step(input logic [23:0] e, input string nm);
    exp_t x;
    @(posedge clk);
    x.exp  = e;
    x.name = nm;
    q.push_back(x);
    #1;
  endtask

  logic [3:0] ops  [11] = '{4'b1101, 4'b1111, 4'b0100, 4'b0101, 4'b0010, 4'b0110,
                            4'b0000, 4'b1100, 4'b0001, 4'b1010, 4'b1000};
  logic [3:0] exes [11] = '{4'b0001, 4'b1001, 4'b0010, 4'b0011, 4'b0100, 4'b0101,
                            4'b0110, 4'b0111, 4'b1000, 4'b0100, 4'b0110};

  initial begin
    rst        = 1'b0;
    bus.flush  = 1'b0;
    bus.freeze = 1'b0;
    set_in(1, 2'b00, 4'b0100, 1, 0, 16'h0);
    step(24'h0, "reset0");
    step(24'h0, "reset1");
    rst = 1'b1;

    for (int i = 0; i < 11; i++) begin
      set_in(1, 2'b00, ops[i], 1, 0, 16'h0);
      step(mk(1, 0, 0, exes[i], 0, 0, !(i == 9 || i == 10), 0, 1, 0, 0),
           $sformatf("dp_op%0d", i));
    end
    set_in(1, 2'b00, 4'b0011, 0, 0, 16'h0);
    step(mk(1, 0, 0, 4'b0001, 0, 0, 1, 0, 0, 0, 0), "dp_default");
    set_in(1, 2'b01, 4'b0000, 1, 0, 16'h0);
    step(mk(1, 0, 0, 4'b0010, 1, 0, 1, 0, 0, 0, 0), "ldr");
    set_in(1, 2'b01, 4'b0000, 0, 0, 16'h0);
    step(mk(1, 0, 0, 4'b0010, 0, 1, 0, 0, 0, 0, 0), "str");
    set_in(0, 2'b00, 4'b0100, 1, 0, 16'h0);
    step(24'h0, "bubble");

    set_in(1, 2'b10, 4'b0000, 1, 0, 16'h002A);
    step(mk(1, 0, 1, 4'b0010, 1, 0, 1, 0, 0, 4'd1, 8'd0), "ldm_r1");
    set_in(1, 2'b11, 4'b0000, 0, 0, 16'hFFFF);
    step(mk(1, 0, 1, 4'b0010, 1, 0, 1, 0, 0, 4'd3, 8'd4), "ldm_r3");
    step(mk(1, 0, 0, 4'b0010, 1, 0, 1, 0, 0, 4'd5, 8'd8), "ldm_r5");
    set_in(1, 2'b10, 4'b0000, 0, 1, 16'h0);
    step(mk(1, 0, 0, 4'b0000, 0, 0, 0, 1, 0, 0, 0), "branch");

    set_in(1, 2'b10, 4'b0000, 0, 0, 16'h0081);
    step(mk(1, 0, 1, 4'b0010, 0, 1, 0, 0, 0, 4'd0, 8'd0), "stm_r0");
    set_in(0, 2'b00, 4'b0000, 0, 0, 16'h0);
    bus.freeze = 1'b1;
    step(mk(1, 0, 1, 4'b0010, 0, 1, 0, 0, 0, 4'd0, 8'd0), "stm_frozen");
    bus.freeze = 1'b0;
    step(mk(1, 0, 0, 4'b0010, 0, 1, 0, 0, 0, 4'd7, 8'd4), "stm_r7");

    set_in(1, 2'b10, 4'b0000, 1, 0, 16'hFFFF);
    step(mk(1, 0, 1, 4'b0010, 1, 0, 1, 0, 0, 4'd0, 8'd0), "ldmf_r0");
    set_in(0, 2'b00, 4'b0000, 0, 0, 16'h0);
    step(mk(1, 0, 1, 4'b0010, 1, 0, 1, 0, 0, 4'd1, 8'd4), "ldmf_r1");
    step(mk(1, 0, 1, 4'b0010, 1, 0, 1, 0, 0, 4'd2, 8'd8), "ldmf_r2");
    bus.flush = 1'b1;
    step(24'h0, "flush");
    bus.flush = 1'b0;
    set_in(1, 2'b00, 4'b0100, 0, 0, 16'h0);
    step(mk(1, 0, 0, 4'b0010, 0, 0, 1, 0, 0, 0, 0), "post_flush_add");

    set_in(1, 2'b10, 4'b0000, 1, 0, 16'hFFFF);
    step(mk(1, 0, 1, 4'b0010, 1, 0, 1, 0, 0, 4'd0, 8'd0), "ldmr_r0");
    set_in(0, 2'b00, 4'b0000, 0, 0, 16'h0);
    step(mk(1, 0, 1, 4'b0010, 1, 0, 1, 0, 0, 4'd1, 8'd4), "ldmr_r1");
    rst = 1'b0;
    step(24'h0, "rst_mid");
    rst = 1'b1;
    set_in(1, 2'b00, 4'b1101, 1, 0, 16'h0);
    step(mk(1, 0, 0, 4'b0001, 0, 0, 1, 0, 1, 0, 0), "post_rst_mov");

    set_in(1, 2'b11, 4'b0000, 0, 0, 16'h0);
    step(mk(1, 1, 0, 4'b0000, 0, 0, 0, 0, 0, 0, 0), "undef");
    set_in(0, 2'b00, 4'b0000, 0, 0, 16'h0);
    step(24'h0, "undef_clear");
    set_in(1, 2'b10, 4'b0000, 1, 0, 16'h0);
    step(mk(1, 0, 0, 4'b0010, 0, 0, 0, 0, 0, 0, 0), "nop_empty_list");
    set_in(0, 2'b00, 4'b0000, 0, 0, 16'h0);

    for (int k = 0; k < 10 && q.size() > 0; k++) @(negedge clk);
    #1;
    if (q.size() > 0) begin
      n_chk++;
      $display("FAIL drain: %0d entries left, expected 0", q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
